uart_tx_fifo: RTL and testbench
===============================

Name: uart_tx_fifo

Overview:
Parametrised asynchronous serial transmitter, the successor to the fixed 8N1 transmitter. Data width, parity mode, stop-bit count and bit period are configurable. A small transmit FIFO with a valid/ready write port allows back-to-back frames without idle gaps. The block sits between a byte-producing core and the board TX pin.

Parameters:
CLK_DIV, 104, clocks per bit (12 MHz / 115200); legal range >= 2
DATA_BITS, 8, payload bits per frame; legal 5..9
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, stop bits per frame; legal 1 or 2
FIFO_DEPTH, 4, FIFO entries; power of two, >= 2

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
in_data  in  DATA_BITS  word to send
in_valid  in  1  in_data is valid
in_ready  out  1  FIFO can accept; a write occurs on a clk edge where in_valid && in_ready
tx  out  1  serial line, registered; idles high
busy  out  1  a frame is on the line or the FIFO is non-empty
fifo_count  out  clog2(FIFO_DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (rst=1 at a clk edge):
  - tx=1, in_ready=1, busy=0, fifo_count=0.
  - FIFO is flushed, FSM returns to IDLE, baud and bit counters are cleared.
  - Reset mid-frame aborts the frame: tx is 1 from the reset edge onward. No partial-frame recovery.
- FIFO:
  - Circular buffer with read/write pointers and a count.
  - in_ready = (count != FIFO_DEPTH). A write while full cannot occur, including when a pop happens in the same cycle.
  - Simultaneous push and pop on a non-full, non-empty FIFO leaves count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: tx=1. If count != 0 at edge E, pop the head into the shift register, clear the baud counter, go to START, tx=0 from edge E.
  - The earliest first start bit is therefore 1 cycle after the accepting edge; an accept at E0 gives tx low from E1.
  - Each state holds its bit for exactly CLK_DIV clocks. The baud counter counts 0..CLK_DIV-1; the terminal count advances the bit.
  - START -> DATA: send DATA_BITS bits LSB first. The bit counter counts 0..DATA_BITS-1.
  - DATA -> PARITY if PARITY != 0, else -> STOP.
  - PARITY bit:
    - even: XOR of the data bits.
    - odd: inverted XOR, so the total number of 1s over data plus parity is odd.
  - STOP: tx=1 for STOP_BITS*CLK_DIV clocks.
  - At the final terminal count of STOP:
    - if count != 0, pop immediately and go to START. The next start bit follows the last stop bit with zero gap.
    - else go to IDLE.
- Frame length: (1 + DATA_BITS + (PARITY!=0) + STOP_BITS) * CLK_DIV clocks exactly.
- The word in the shift register is latched at pop. in_data and FIFO writes during a frame do not affect the frame in flight.
- busy = (state != IDLE) || (count != 0).
- tx is driven from a flop and is glitch-free.
- No combinational path from in_valid to in_ready.
- Unused widths: in_data bits are all significant; no padding.

Test Plan:
- CLK_DIV=4, 8N1. Write 0x55 at E0 -> tx low E1..E4, then 1,0,1,0,1,0,1,0 each held 4 clocks, stop high 4 clocks. busy falls 40 cycles after E1. in_ready stays 1.
- PARITY=2 (even), write 0x07 -> parity bit 1. PARITY=1 (odd), write 0x07 -> parity bit 0. Frame is 11*CLK_DIV clocks.
- DATA_BITS=7, STOP_BITS=2, write 0x41 -> LSB-first bits 1,0,0,0,0,0,1, then 2*CLK_DIV clocks high. Total 10*CLK_DIV clocks.
- FIFO_DEPTH=4, in_valid held high with 0xA0..0xA5 -> first word popped immediately. in_ready drops after the 5th accept (count=4). The remaining words go out back-to-back with no idle cycle between stop and start bits. fifo_count returns to 0.
- Assert rst mid-DATA with 2 words queued -> tx=1, fifo_count=0, busy=0 on the reset edge. A new write afterwards transmits normally.
- Push and pop in the same cycle (count=2 while a frame ends) -> count stays 2 and data order is preserved (FIFO order check via a scoreboard).

Source files
------------

// File: rtl/uart_tx_fifo.sv
// Parametrised serial transmitter with a small transmit FIFO.
// Frame: start bit, DATA_BITS payload bits LSB first, optional parity, STOP_BITS stop bits.
// A new frame starts on the edge after the last stop bit whenever the FIFO holds a word.
module uart_tx_fifo #(
  parameter int unsigned CLK_DIV    = 104,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_BITS-1:0]          in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW  = PtrW + 1;
  localparam int unsigned BaudW = $clog2(CLK_DIV);
  localparam int unsigned BitW  = $clog2(DATA_BITS);

  localparam logic [BaudW-1:0] BaudLast = BaudW'(CLK_DIV - 1);
  localparam logic [BitW-1:0]  DataLast = BitW'(DATA_BITS - 1);
  localparam logic [BitW-1:0]  StopLast = BitW'(STOP_BITS - 1);
  localparam logic [CntW-1:0]  CntFull  = CntW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } state_e;

  // FIFO storage and bookkeeping
  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]      wr_ptr_q;
  logic [PtrW-1:0]      rd_ptr_q;
  logic [CntW-1:0]      count_q;
  logic                 push;
  logic                 pop;
  logic [DATA_BITS-1:0] head;

  // Transmitter state
  state_e               state_q, state_d;
  logic [BaudW-1:0]     baud_q, baud_d;
  logic [BitW-1:0]      bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 tx_q, tx_d;
  logic                 baud_tc;
  logic                 have_word;

  // in_ready depends only on the registered count, never on in_valid.
  assign in_ready   = (count_q != CntFull);
  assign push       = in_valid && in_ready;
  assign head       = mem_q[rd_ptr_q];
  assign have_word  = (count_q != '0);
  assign baud_tc    = (baud_q == BaudLast);

  assign tx         = tx_q;
  assign busy       = (state_q != StIdle) || have_word;
  assign fifo_count = count_q;

  // FIFO data array; written only on an accepted handshake
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at a power-of-two depth
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Transmitter next-state: bit sequencing, baud timing and the registered line level
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    tx_d    = tx_q;
    pop     = 1'b0;

    unique case (state_q)
      StIdle: begin
        tx_d = 1'b1;
        if (have_word) begin
          pop = 1'b1;
        end
      end

      StStart: begin
        if (baud_tc) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = StData;
          tx_d    = shift_q[0];
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end

      StData: begin
        if (baud_tc) begin
          baud_d = '0;
          if (bit_q == DataLast) begin
            bit_d = '0;
            if (PARITY != 0) begin
              state_d = StParity;
              tx_d    = par_q;
            end else begin
              state_d = StStop;
              tx_d    = 1'b1;
            end
          end else begin
            bit_d   = bit_q + 1'b1;
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end

      StParity: begin
        if (baud_tc) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = StStop;
          tx_d    = 1'b1;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end

      StStop: begin
        tx_d = 1'b1;
        if (baud_tc) begin
          baud_d = '0;
          if (bit_q == StopLast) begin
            bit_d = '0;
            // Chain straight into the next frame when one is queued.
            if (have_word) begin
              pop = 1'b1;
            end else begin
              state_d = StIdle;
            end
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end

      default: begin
        state_d = StIdle;
        tx_d    = 1'b1;
      end
    endcase

    // A pop latches the word and its parity and drives the start bit from this edge.
    if (pop) begin
      state_d = StStart;
      baud_d  = '0;
      bit_d   = '0;
      shift_d = head;
      par_d   = (PARITY == 1) ? ~(^head) : (^head);
      tx_d    = 1'b0;
    end
  end

  // Transmitter state register; reset aborts any frame and parks the line high
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: one FIFO-focused instance checked cycle by cycle against a
// frame-level model, plus four single-frame instances covering the other configurations.
module tb_uart_tx_fifo;

  localparam int DIV_A   = 4;
  localparam int LEN_A   = 40;
  localparam int DEPTH_A = 4;

  logic       clk;
  logic       rst;
  logic [8:0] din;
  logic [4:0] vld;
  logic [4:0] rdy;
  logic [4:0] txs;
  logic [4:0] bsy;
  logic [2:0] cnt_a, cnt_b, cnt_c;
  logic [1:0] cnt_d, cnt_e;

  int    n_chk = 0;
  int    n_err = 0;
  int    cyc   = 0;
  string cur_test = "";

  // Frame-level model of instance A: pending words, word on the line, cycle within frame
  logic [7:0] m_q[$];
  logic       m_active = 1'b0;
  logic [7:0] m_word   = 8'h00;
  int         m_cyc    = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_fifo #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_a (
    .clk(clk), .rst(rst), .in_data(din[7:0]), .in_valid(vld[0]), .in_ready(rdy[0]),
    .tx(txs[0]), .busy(bsy[0]), .fifo_count(cnt_a)
  );
  uart_tx_fifo #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u_b (
    .clk(clk), .rst(rst), .in_data(din[7:0]), .in_valid(vld[1]), .in_ready(rdy[1]),
    .tx(txs[1]), .busy(bsy[1]), .fifo_count(cnt_b)
  );
  uart_tx_fifo #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) u_c (
    .clk(clk), .rst(rst), .in_data(din[7:0]), .in_valid(vld[2]), .in_ready(rdy[2]),
    .tx(txs[2]), .busy(bsy[2]), .fifo_count(cnt_c)
  );
  uart_tx_fifo #(.CLK_DIV(5), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(2)) u_d (
    .clk(clk), .rst(rst), .in_data(din[6:0]), .in_valid(vld[3]), .in_ready(rdy[3]),
    .tx(txs[3]), .busy(bsy[3]), .fifo_count(cnt_d)
  );
  uart_tx_fifo #(.CLK_DIV(2), .DATA_BITS(9), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(2)) u_e (
    .clk(clk), .rst(rst), .in_data(din[8:0]), .in_valid(vld[4]), .in_ready(rdy[4]),
    .tx(txs[4]), .busy(bsy[4]), .fifo_count(cnt_e)
  );

  // Line level of frame slot `slot` (each slot lasts one bit period) for word w
  function automatic logic frame_bit(input logic [8:0] w, input int slot, input int dbits,
                                     input int par);
    int ones;
    ones = 0;
    for (int i = 0; i < dbits; i++) begin
      if (w[i]) ones++;
    end
    if (slot == 0) return 1'b0;
    if (slot <= dbits) return w[slot-1];
    if (par != 0 && slot == dbits + 1) begin
      if (par == 2) return ((ones % 2) == 1);
      return ((ones % 2) == 0);
    end
    return 1'b1;
  endfunction

  // One clock on instance A: drive, advance the model on the edge, compare at the negedge
  task automatic step_a(input logic v, input logic [7:0] d, input logic r, output logic pushed);
    logic push;
    logic exp_tx;
    logic exp_busy;
    logic exp_rdy;
    push   = v && !r && (m_q.size() != DEPTH_A);
    vld[0] = v;
    din    = {1'b0, d};
    rst    = r;
    @(posedge clk);
    if (r) begin
      m_q.delete();
      m_active = 1'b0;
      m_cyc    = 0;
    end else begin
      if (m_active) begin
        m_cyc++;
        if (m_cyc == LEN_A) m_active = 1'b0;
      end
      if (!m_active && m_q.size() != 0) begin
        m_word   = m_q.pop_front();
        m_active = 1'b1;
        m_cyc    = 0;
      end
      if (push) m_q.push_back(d);
    end
    pushed = push;
    @(negedge clk);
    exp_tx   = m_active ? frame_bit({1'b0, m_word}, m_cyc / DIV_A, 8, 0) : 1'b1;
    exp_busy = m_active || (m_q.size() != 0);
    exp_rdy  = (m_q.size() != DEPTH_A);
    n_chk++;
    if (txs[0] !== exp_tx) begin
      n_err++;
      $display("FAIL %s tx cyc=%0d got=%b exp=%b", cur_test, cyc, txs[0], exp_tx);
    end
    n_chk++;
    if (bsy[0] !== exp_busy) begin
      n_err++;
      $display("FAIL %s busy cyc=%0d got=%b exp=%b", cur_test, cyc, bsy[0], exp_busy);
    end
    n_chk++;
    if (cnt_a !== 3'(m_q.size())) begin
      n_err++;
      $display("FAIL %s fifo_count cyc=%0d got=%0d exp=%0d", cur_test, cyc, cnt_a, m_q.size());
    end
    n_chk++;
    if (rdy[0] !== exp_rdy) begin
      n_err++;
      $display("FAIL %s in_ready cyc=%0d got=%b exp=%b", cur_test, cyc, rdy[0], exp_rdy);
    end
  endtask

  task automatic drain_a();
    logic p;
    for (int n = 0; n < 400 && (m_active || m_q.size() != 0); n++) step_a(1'b0, 8'h00, 1'b0, p);
    for (int n = 0; n < 3; n++) step_a(1'b0, 8'h00, 1'b0, p);
    n_chk++;
    if (m_active || m_q.size() != 0) begin
      n_err++;
      $display("FAIL %s drain timeout got=busy exp=idle", cur_test);
    end
  endtask

  task automatic test_reset();
    logic p;
    cur_test = "reset";
    vld = '0;
    din = '0;
    @(negedge clk);
    step_a(1'b0, 8'h00, 1'b1, p);
    step_a(1'b0, 8'h00, 1'b1, p);
    n_chk++;
    if (txs[4:1] !== 4'b1111 || bsy[4:1] !== 4'b0000 || rdy[4:1] !== 4'b1111) begin
      n_err++;
      $display("FAIL reset others tx=%b busy=%b rdy=%b exp=1111/0000/1111", txs[4:1], bsy[4:1],
               rdy[4:1]);
    end
    n_chk++;
    if (cnt_b !== 3'd0 || cnt_c !== 3'd0 || cnt_d !== 2'd0 || cnt_e !== 2'd0) begin
      n_err++;
      $display("FAIL reset counts got=%0d,%0d,%0d,%0d exp=0", cnt_b, cnt_c, cnt_d, cnt_e);
    end
    step_a(1'b0, 8'h00, 1'b0, p);
  endtask

  task automatic test_8n1();
    logic p;
    int   first_idle;
    logic rdy_drop;
    cur_test   = "8n1";
    first_idle = -1;
    rdy_drop   = 1'b0;
    step_a(1'b1, 8'h55, 1'b0, p);
    for (int k = 1; k <= 60; k++) begin
      step_a(1'b0, 8'h00, 1'b0, p);
      if (first_idle < 0 && bsy[0] === 1'b0) first_idle = k;
      if (rdy[0] !== 1'b1) rdy_drop = 1'b1;
    end
    // busy drops on the edge 40 clocks after the first start-bit edge
    n_chk++;
    if (first_idle != 41) begin
      n_err++;
      $display("FAIL 8n1 busy_fall got=%0d exp=41", first_idle);
    end
    n_chk++;
    if (rdy_drop !== 1'b0) begin
      n_err++;
      $display("FAIL 8n1 in_ready_stable got=%b exp=0", rdy_drop);
    end
  endtask

  task automatic test_fifo_burst();
    logic p;
    int   idx;
    int   full_at;
    cur_test = "burst";
    idx      = 0;
    full_at  = -1;
    for (int n = 0; n < 400 && idx < 6; n++) begin
      step_a(1'b1, 8'(8'hA0 + idx), 1'b0, p);
      if (p) idx++;
      if (full_at < 0 && rdy[0] === 1'b0) full_at = idx;
    end
    n_chk++;
    if (full_at != 5) begin
      n_err++;
      $display("FAIL burst full_after_accepts got=%0d exp=5", full_at);
    end
    n_chk++;
    if (idx != 6) begin
      n_err++;
      $display("FAIL burst accepted got=%0d exp=6", idx);
    end
    drain_a();
    n_chk++;
    if (cnt_a !== 3'd0) begin
      n_err++;
      $display("FAIL burst final_count got=%0d exp=0", cnt_a);
    end
  endtask

  task automatic test_push_pop();
    logic p;
    cur_test = "push_pop";
    for (int i = 0; i < 3; i++) step_a(1'b1, 8'($urandom), 1'b0, p);
    for (int n = 0; n < 100 && !(m_active && m_cyc == LEN_A - 1); n++) begin
      step_a(1'b0, 8'h00, 1'b0, p);
    end
    step_a(1'b1, 8'($urandom), 1'b0, p);
    n_chk++;
    if (cnt_a !== 3'd2) begin
      n_err++;
      $display("FAIL push_pop count got=%0d exp=2", cnt_a);
    end
    drain_a();
  endtask

  task automatic test_reset_mid();
    logic p;
    cur_test = "reset_mid";
    for (int i = 0; i < 3; i++) step_a(1'b1, 8'($urandom), 1'b0, p);
    for (int n = 0; n < 100 && !(m_active && m_cyc == 14); n++) step_a(1'b0, 8'h00, 1'b0, p);
    step_a(1'b0, 8'h00, 1'b1, p);
    n_chk++;
    if (txs[0] !== 1'b1 || cnt_a !== 3'd0 || bsy[0] !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid tx=%b count=%0d busy=%b exp=1/0/0", txs[0], cnt_a, bsy[0]);
    end
    step_a(1'b0, 8'h00, 1'b0, p);
    step_a(1'b1, 8'h3C, 1'b0, p);
    drain_a();
  endtask

  task automatic test_random();
    logic p;
    cur_test = "random";
    for (int n = 0; n < 600; n++) begin
      step_a(($urandom % 3) == 0, 8'($urandom), 1'b0, p);
    end
    drain_a();
  endtask

  // Single frame on one of the auxiliary instances, checked slot by slot
  task automatic test_frame(input int idx, input int div, input int dbits, input int par,
                            input int stops, input logic [8:0] w);
    int   len;
    logic exp;
    len      = (1 + dbits + ((par != 0) ? 1 : 0) + stops) * div;
    rst      = 1'b0;
    vld[0]   = 1'b0;
    din      = w;
    vld[idx] = 1'b1;
    @(posedge clk);
    #1 vld[idx] = 1'b0;
    @(negedge clk);
    n_chk++;
    if (txs[idx] !== 1'b1 || bsy[idx] !== 1'b1) begin
      n_err++;
      $display("FAIL frame%0d pre_start tx=%b busy=%b exp=1/1", idx, txs[idx], bsy[idx]);
    end
    for (int c = 0; c < len; c++) begin
      @(negedge clk);
      exp = frame_bit(w, c / div, dbits, par);
      n_chk++;
      if (txs[idx] !== exp || bsy[idx] !== 1'b1) begin
        n_err++;
        $display("FAIL frame%0d word=%h c=%0d tx=%b busy=%b exp=%b/1", idx, w, c, txs[idx],
                 bsy[idx], exp);
      end
    end
    @(negedge clk);
    n_chk++;
    if (txs[idx] !== 1'b1 || bsy[idx] !== 1'b0 || rdy[idx] !== 1'b1) begin
      n_err++;
      $display("FAIL frame%0d end tx=%b busy=%b rdy=%b exp=1/0/1", idx, txs[idx], bsy[idx],
               rdy[idx]);
    end
  endtask

  task automatic test_configs();
    cur_test = "configs";
    test_frame(1, 4, 8, 2, 1, 9'h007);
    test_frame(2, 4, 8, 1, 1, 9'h007);
    test_frame(3, 5, 7, 0, 2, 9'h041);
    test_frame(4, 2, 9, 1, 1, 9'h100);
    for (int i = 0; i < 3; i++) begin
      test_frame(1, 4, 8, 2, 1, {1'b0, 8'($urandom)});
      test_frame(2, 4, 8, 1, 1, {1'b0, 8'($urandom)});
      test_frame(3, 5, 7, 0, 2, {2'b00, 7'($urandom)});
      test_frame(4, 2, 9, 1, 1, 9'($urandom));
    end
  endtask

  initial begin
    rst = 1'b1;
    vld = '0;
    din = '0;
    test_reset();
    test_8n1();
    test_fifo_burst();
    test_push_pop();
    test_reset_mid();
    test_random();
    test_configs();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
